uart_rx_os16: RTL and testbench

//  Standalone UART receiver, 8N1 (8E1 optional), 16x oversampled with mid-bit sampling.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_os16.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_os16.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and baud divider helper.
// Used by the receiver and by the transmitter's baud generator.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick generator: one-cycle pulse every baud_div() clocks.
// Never restarted by line activity so RX and TX can share the same block.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1, 16x oversampled with mid-bit sampling and dout/rdy/rdy_clr handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_err pulse.
//
//  state  | meaning
//  IDLE   | line idle, looking for a low sample on a tick
//  START  | validating start bit at its middle (sample 7)
//  DATA   | shifting 8 data bits LSB first, sampled at count 15
//  PARITY | checking the even-parity bit (UART_RX_PARITY_EN only)
//  STOP   | sampling stop bit; commit byte or flag frame_err
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] S_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);

    logic           tick;
    logic           rx_m;
    logic           rx_s;
    state_t         state;
    logic [SCW-1:0] scnt;
    logic [2:0]     bcnt;
    logic [7:0]     shreg;
    logic           stop_ok;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud_tick (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_err_q;

    assign stop_ok    = rx_s && !par_bad;
    assign parity_err = par_err_q;
`else
    assign stop_ok    = rx_s;
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            dout      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            if (rdy_clr) begin
                rdy <= 1'b0;
            end
            if (tick) begin
                scnt <= scnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            scnt  <= '0;
                        end
                    end
                    START: begin
                        if (scnt == S_MID) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state <= DATA;
                                scnt  <= '0;
                                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                                par_bad <= 1'b0;
`endif
                            end
                        end
                    end
                    DATA: begin
                        if (scnt == S_LAST) begin
                            shreg <= {rx_s, shreg[7:1]};
                            bcnt  <= bcnt + 1'b1;
                            if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (scnt == S_LAST) begin
                            par_bad   <= rx_s ^ (^shreg);
                            par_err_q <= rx_s ^ (^shreg);
                            state     <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (scnt == S_LAST) begin
                            state <= IDLE;
                            if (stop_ok) begin
                                // A commit always wins over a simultaneous rdy_clr.
                                dout    <= shreg;
                                rdy     <= 1'b1;
                                overrun <= rdy && !rdy_clr;
                            end
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: scoreboard of expected bytes popped on each commit.
// Parity scenario is included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os16;

    localparam int BIT = 432;
    localparam int DIV = 27;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 8 + 16 * 10;
`else
    localparam int FRAME_TICKS = 8 + 16 * 9;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int er = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_pe = 0;
    int rdy_age = 0;
    int clr_at = -1;
    bit auto_clr = 1'b0;
    logic rdy_q = 1'b0;
    logic [7:0] sb[$];

    uart_rx_os16 dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .rx         (rx),
        .rdy_clr    (rdy_clr),
        .dout       (dout),
        .rdy        (rdy),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Commit monitor: a new byte shows up as rdy rising or as an overrun pulse.
    always @(posedge clk_50m) begin
        logic [7:0] e;
        #1;
        if (!rst_n) begin
            rdy_q = 1'b0;
        end else begin
            if (frame_err)  n_fe++;
            if (overrun)    n_ov++;
            if (parity_err) n_pe++;
            if ((rdy && !rdy_q) || overrun) begin
                er = cyc;
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("dout", {24'd0, dout}, {24'd0, e});
                end
            end
            rdy_q = rdy;
        end
    end

    // Host side: optional auto-acknowledge 2 cycles after rdy, or one pulse at a chosen cycle.
    always @(negedge clk_50m) begin
        rdy_age = rdy ? rdy_age + 1 : 0;
        rdy_clr = (auto_clr && rdy_age == 2) || (cyc == clr_at);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d;
        idle(BIT);
`endif
        rx = stop_bit;
        idle(BIT);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] d);
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT);
        end
        rx = ~(^d);
        idle(BIT);
        rx = 1'b1;
        idle(BIT);
    endtask
`endif

    initial begin
        logic [7:0] sweep [6];
        int fe0;
        int ov0;
        int pe0;
        sweep = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3};

        idle(5);
        chk("rst_dout", {24'd0, dout}, 32'h00);
        chk("rst_rdy", {31'd0, rdy}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 0);
        rst_n = 1'b1;
        idle(50);

        // 1: single byte with acknowledge
        auto_clr = 1'b1;
        fe0 = n_fe;
        ov0 = n_ov;
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_rdy_cleared", {31'd0, rdy}, 0);
        chk("t1_dout_held", {24'd0, dout}, 32'hA5);
        chk("t1_no_fe", n_fe - fe0, 0);
        chk("t1_no_ov", n_ov - ov0, 0);

        // 2: back-to-back bytes
        foreach (sweep[i]) begin
            sb.push_back(sweep[i]);
            send_byte(sweep[i], 1'b1);
        end
        idle(100);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_no_ov", n_ov - ov0, 0);
        chk("t2_no_fe", n_fe - fe0, 0);

        // 3: short low glitch on idle line
        rx = 1'b0;
        idle(60);
        chk("t3_busy_high", {31'd0, busy}, 1);
        idle(40);
        rx = 1'b1;
        idle(400);
        chk("t3_busy_low", {31'd0, busy}, 0);
        chk("t3_rdy_low", {31'd0, rdy}, 0);
        chk("t3_no_fe", n_fe - fe0, 0);

        // 4: framing error then recovery
        send_byte(8'h3C, 1'b0);
        idle(600);
        chk("t4_fe_once", n_fe - fe0, 1);
        chk("t4_rdy_low", {31'd0, rdy}, 0);
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle(300);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_fe_total", n_fe - fe0, 1);

        // 5a: overrun
        auto_clr = 1'b0;
        ov0 = n_ov;
        sb.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        sb.push_back(8'h22);
        send_byte(8'h22, 1'b1);
        chk("t5_ov_once", n_ov - ov0, 1);
        chk("t5_dout", {24'd0, dout}, 32'h22);
        chk("t5_rdy", {31'd0, rdy}, 1);
        chk("t5_sb_empty", sb.size(), 0);

        // 5b: align the start bit to a tick so the commit edge is known, ack exactly then
        for (int k = 0; k < DIV && ((cyc + 3 - er) % DIV) != 0; k++) @(negedge clk_50m);
        clr_at = cyc + 3 + FRAME_TICKS * DIV - 1;
        send_byte(8'h33, 1'b1);
        clr_at = -1;
        chk("t5b_no_ov", n_ov - ov0, 1);
        chk("t5b_rdy", {31'd0, rdy}, 1);
        chk("t5b_dout", {24'd0, dout}, 32'h33);

        // 6: reset in the middle of a frame
        fork
            send_byte(8'h77, 1'b1);
        join_none
        idle(4 * BIT + BIT / 2);
        chk("t6_busy_mid", {31'd0, busy}, 1);
        rst_n = 1'b0;
        idle(3);
        chk("t6_rst_dout", {24'd0, dout}, 32'h00);
        chk("t6_rst_rdy", {31'd0, rdy}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        wait fork;
        idle(10);
        rst_n = 1'b1;
        idle(100);
        auto_clr = 1'b1;
        sb.push_back(8'h88);
        send_byte(8'h88, 1'b1);
        idle(300);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_dout", {24'd0, dout}, 32'h88);

`ifdef UART_RX_PARITY_EN
        pe0 = n_pe;
        send_bad_parity(8'h03);
        idle(300);
        chk("t7_pe_once", n_pe - pe0, 1);
        chk("t7_rdy_low", {31'd0, rdy}, 0);
        chk("t7_dout_kept", {24'd0, dout}, 32'h88);
        chk("pe_total", n_pe, 1);
`else
        pe0 = 0;
        chk("pe_total", n_pe - pe0, 0);
`endif

        idle(100);
        chk("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
